// File: rtl/counter_sweep_ctrl_if.sv
// Bus between the sweep sequencer, the test/control logic that starts it and
// the free-running 4-bit up/down counter it steers.
interface counter_sweep_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic         abort;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] passes;
    logic [W-1:0] Count;
    logic         UD;
    logic         CntClr_n;
    logic         busy;
    logic         done;
    logic [W-1:0] pass_left;
    logic         cfg_err;
    logic         err;

    // slave: the sequencer; master: control logic plus the counter it drives
    modport slave (
        input  start, abort, lo, hi, passes, Count,
        output UD, CntClr_n, busy, done, pass_left, cfg_err, err
    );
    modport master (
        output start, abort, lo, hi, passes, Count,
        input  UD, CntClr_n, busy, done, pass_left, cfg_err, err
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweeps a free-running up/down counter 0 -> hi, then between lo and hi for N passes.
// Optional SWEEP_CHECK_EN adds a shadow counter and a sticky err flag.
module counter_sweep_ctrl #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 Clear,
    counter_sweep_ctrl_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [W-1:0] ONE = 1;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_pass_left;
    logic         r_ud;
    logic         r_cntclr_n;
    logic         r_cfg_err;
    logic         w_cfg_ok;
    logic         w_accept;
    logic         w_at_top;
    logic         w_at_bottom;
    logic         w_busy;
    logic         w_done;

    assign w_cfg_ok    = (bus.lo < bus.hi) && (bus.passes != '0);
    assign w_accept    = (r_state == S_IDLE) && bus.start && w_cfg_ok;
    // Turn one count early: the counter lands on the bound on the same edge.
    assign w_at_top    = (bus.Count == (r_hi - ONE));
    assign w_at_bottom = (bus.Count == (r_lo + ONE));

    always_ff @(posedge clk) begin
        if (Clear) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_UP;
            S_UP: begin
                if (bus.abort)     w_next = S_IDLE;
                else if (w_at_top) w_next = S_DOWN;
            end
            S_DOWN: begin
                if (bus.abort)        w_next = S_IDLE;
                else if (w_at_bottom) w_next = (r_pass_left > ONE) ? S_UP : S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == S_UP) || (r_state == S_DOWN);
        w_done      = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            r_lo        <= '0;
            r_hi        <= '0;
            r_pass_left <= '0;
            r_ud        <= 1'b0;
            r_cntclr_n  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lo        <= bus.lo;
                        r_hi        <= bus.hi;
                        r_pass_left <= bus.passes;
                        r_cntclr_n  <= 1'b1;
                        r_ud        <= 1'b0;
                    end else if (bus.start) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                S_UP: begin
                    if (bus.abort) begin
                        r_cntclr_n  <= 1'b0;
                        r_ud        <= 1'b0;
                        r_pass_left <= '0;
                    end else if (w_at_top) begin
                        r_ud <= 1'b1;
                    end
                end
                S_DOWN: begin
                    if (bus.abort) begin
                        r_cntclr_n  <= 1'b0;
                        r_ud        <= 1'b0;
                        r_pass_left <= '0;
                    end else if (w_at_bottom) begin
                        r_ud <= 1'b0;
                        if (r_pass_left > ONE) begin
                            r_pass_left <= r_pass_left - ONE;
                        end else begin
                            r_pass_left <= '0;
                            r_cntclr_n  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.UD        = r_ud;
    assign bus.CntClr_n  = r_cntclr_n;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass_left = r_pass_left;
    assign bus.cfg_err   = r_cfg_err;

`ifdef SWEEP_CHECK_EN
    logic [W-1:0] r_exp;
    logic         r_err;

    // Shadow of the counter, advanced by the same registered controls it sees.
    always_ff @(posedge clk) begin
        if (Clear) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            if (!r_cntclr_n) r_exp <= '0;
            else if (r_ud)   r_exp <= r_exp - ONE;
            else             r_exp <= r_exp + ONE;

            if (w_accept)                            r_err <= 1'b0;
            else if (w_busy && (bus.Count != r_exp)) r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl: a behavioural counter closes the loop,
// expected Count sequences are hand-derived tables popped from exp_q.
module tb_counter_sweep_ctrl;
    logic       clk = 1'b0;
    logic       Clear = 1'b1;
    logic [3:0] tb_cnt = 4'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic [1:0] dbg_state;
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

`ifdef SWEEP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    counter_sweep_ctrl_if #(.W(4)) cif ();

    counter_sweep_ctrl #(.W(4)) dut (
        .clk         (clk),
        .Clear       (Clear),
        .bus         (cif.slave),
        .o_dbg_state (dbg_state)
    );

    // clock / counter environment
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cif.CntClr_n) tb_cnt <= 4'd0;
        else if (cif.UD)   tb_cnt <= tb_cnt - 4'd1;
        else               tb_cnt <= tb_cnt + 4'd1;
    end

    assign cif.Count = force_en ? force_val : tb_cnt;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cif.start  = 1'b0;
        cif.abort  = 1'b0;
        cif.lo     = 4'd0;
        cif.hi     = 4'd0;
        cif.passes = 4'd0;
    endtask

    task automatic start_sweep(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] p);
        cif.start  = 1'b1;
        cif.lo     = lo;
        cif.hi     = hi;
        cif.passes = p;
        tick();
        cif.start = 1'b0;
    endtask

    task automatic test_reset();
        Clear = 1'b1;
        drive_idle();
        tick();
        tick();
        checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", cif.busy); end
        checks++; if (cif.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", cif.done); end
        checks++; if (cif.UD !== 1'b0) begin errors++; $display("FAIL rst_ud: got %0b want 0", cif.UD); end
        checks++; if (cif.CntClr_n !== 1'b0) begin errors++; $display("FAIL rst_clr: got %0b want 0", cif.CntClr_n); end
        checks++; if (cif.pass_left !== 4'd0) begin errors++; $display("FAIL rst_pass_left: got %0d want 0", cif.pass_left); end
        checks++; if (cif.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %0b want 0", cif.cfg_err); end
        checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", cif.err); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        Clear = 1'b0;
        tick();
        checks++; if (cif.Count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cif.Count); end

        // reset in the middle of a sweep
        start_sweep(4'd2, 4'd5, 4'd1);
        tick(); tick(); tick();
        checks++; if (cif.Count !== 4'd3 || dbg_state !== 2'd1) begin errors++; $display("FAIL mid_pre: got count %0d state %0d want 3 1", cif.Count, dbg_state); end
        Clear = 1'b1;
        tick();
        checks++; if (cif.busy !== 1'b0 || cif.CntClr_n !== 1'b0 || cif.UD !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got busy %0b clr %0b ud %0b want 0 0 0", cif.busy, cif.CntClr_n, cif.UD); end
        checks++; if (cif.pass_left !== 4'd0 || cif.done !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_st: got pl %0d done %0b state %0d want 0 0 0", cif.pass_left, cif.done, dbg_state); end
        checks++; if (cif.Count !== 4'd4) begin errors++; $display("FAIL mid_rst_cnt1: got %0d want 4", cif.Count); end
        Clear = 1'b0;
        tick();
        checks++; if (cif.Count !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt2: got %0d want 0", cif.Count); end
    endtask

    task automatic test_sweep_basic();
        logic [3:0] e;
        logic [3:0] want_pl;
        start_sweep(4'd2, 4'd5, 4'd2);
        checks++; if (cif.Count !== 4'd0 || cif.busy !== 1'b1 || cif.pass_left !== 4'd2) begin errors++; $display("FAIL basic_e0: got cnt %0d busy %0b pl %0d want 0 1 2", cif.Count, cif.busy, cif.pass_left); end
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
        for (int k = 1; k <= 14; k++) begin
            e = exp_q.pop_front();
            tick();
            want_pl = (k < 8) ? 4'd2 : ((k < 14) ? 4'd1 : 4'd0);
            checks++; if (cif.Count !== e) begin errors++; $display("FAIL basic_count k=%0d: got %0d want %0d", k, cif.Count, e); end
            checks++; if (cif.done !== (k == 14)) begin errors++; $display("FAIL basic_done k=%0d: got %0b want %0b", k, cif.done, (k == 14)); end
            checks++; if (cif.pass_left !== want_pl) begin errors++; $display("FAIL basic_pl k=%0d: got %0d want %0d", k, cif.pass_left, want_pl); end
        end
        tick();
        checks++; if (cif.done !== 1'b0 || cif.busy !== 1'b0 || cif.Count !== 4'd0) begin errors++; $display("FAIL basic_end: got done %0b busy %0b cnt %0d want 0 0 0", cif.done, cif.busy, cif.Count); end
    endtask

    task automatic test_narrow();
        logic [3:0] e;
        start_sweep(4'd3, 4'd4, 4'd1);
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3};
        for (int k = 1; k <= 5; k++) begin
            e = exp_q.pop_front();
            tick();
            checks++; if (cif.Count !== e) begin errors++; $display("FAIL narrow1_count k=%0d: got %0d want %0d", k, cif.Count, e); end
            checks++; if (cif.done !== (k == 5) || cif.busy !== (k < 5)) begin errors++; $display("FAIL narrow1_flags k=%0d: got done %0b busy %0b", k, cif.done, cif.busy); end
        end
        tick();
        start_sweep(4'd3, 4'd4, 4'd3);
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3};
        for (int k = 1; k <= 9; k++) begin
            e = exp_q.pop_front();
            tick();
            checks++; if (cif.Count !== e) begin errors++; $display("FAIL narrow3_count k=%0d: got %0d want %0d", k, cif.Count, e); end
            checks++; if (cif.done !== (k == 9) || cif.busy !== (k < 9)) begin errors++; $display("FAIL narrow3_flags k=%0d: got done %0b busy %0b", k, cif.done, cif.busy); end
        end
        tick();
    endtask

    task automatic test_cfg_err();
        logic [3:0] v_lo[3] = '{4'd5, 4'd1, 4'd6};
        logic [3:0] v_hi[3] = '{4'd5, 4'd3, 4'd2};
        logic [3:0] v_p[3]  = '{4'd1, 4'd0, 4'd2};
        for (int i = 0; i < 3; i++) begin
            start_sweep(v_lo[i], v_hi[i], v_p[i]);
            checks++; if (cif.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse v%0d: got %0b want 1", i, cif.cfg_err); end
            checks++; if (cif.busy !== 1'b0 || cif.CntClr_n !== 1'b0) begin errors++; $display("FAIL cfg_err_idle v%0d: got busy %0b clr %0b want 0 0", i, cif.busy, cif.CntClr_n); end
            tick();
            checks++; if (cif.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_end v%0d: got %0b want 0", i, cif.cfg_err); end
        end
    endtask

    task automatic test_abort();
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        checks++; if (cif.busy !== 1'b0 || cif.cfg_err !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %0b cfg_err %0b want 0 0", cif.busy, cif.cfg_err); end

        start_sweep(4'd2, 4'd5, 4'd2);
        tick();
        // a start mid-sweep with different bounds must change nothing
        start_sweep(4'd0, 4'd15, 4'd9);
        checks++; if (cif.cfg_err !== 1'b0 || cif.Count !== 4'd2) begin errors++; $display("FAIL start_in_sweep: got cfg_err %0b cnt %0d want 0 2", cif.cfg_err, cif.Count); end
        tick(); tick(); tick(); tick();
        checks++; if (cif.Count !== 4'd4 || dbg_state !== 2'd2) begin errors++; $display("FAIL abort_pre: got cnt %0d state %0d want 4 2", cif.Count, dbg_state); end
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        checks++; if (cif.busy !== 1'b0 || cif.done !== 1'b0 || cif.pass_left !== 4'd0) begin errors++; $display("FAIL abort_st: got busy %0b done %0b pl %0d want 0 0 0", cif.busy, cif.done, cif.pass_left); end
        checks++; if (cif.CntClr_n !== 1'b0 || cif.UD !== 1'b0 || cif.Count !== 4'd3) begin errors++; $display("FAIL abort_ctl: got clr %0b ud %0b cnt %0d want 0 0 3", cif.CntClr_n, cif.UD, cif.Count); end
        tick();
        checks++; if (cif.Count !== 4'd0 || cif.done !== 1'b0) begin errors++; $display("FAIL abort_cnt: got cnt %0d done %0b want 0 0", cif.Count, cif.done); end

        // start and abort together in IDLE: start wins
        cif.abort = 1'b1;
        start_sweep(4'd1, 4'd3, 4'd1);
        cif.abort = 1'b0;
        checks++; if (cif.busy !== 1'b1 || cif.pass_left !== 4'd1) begin errors++; $display("FAIL start_wins: got busy %0b pl %0d want 1 1", cif.busy, cif.pass_left); end
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        start_sweep(4'd0, 4'd15, 4'd1);
        for (int k = 1; k <= 30; k++) exp_q.push_back((k <= 15) ? 4'(k) : 4'(30 - k));
        for (int k = 1; k <= 30; k++) begin
            e = exp_q.pop_front();
            tick();
            checks++; if (cif.Count !== e) begin errors++; $display("FAIL full_count k=%0d: got %0d want %0d", k, cif.Count, e); end
            checks++; if (cif.done !== (k == 30)) begin errors++; $display("FAIL full_done k=%0d: got %0b want %0b", k, cif.done, (k == 30)); end
        end
        // start held from the DONE cycle: ignored there, accepted one edge later
        cif.start  = 1'b1;
        cif.lo     = 4'd3;
        cif.hi     = 4'd4;
        cif.passes = 4'd1;
        tick();
        checks++; if (cif.busy !== 1'b0 || cif.cfg_err !== 1'b0 || cif.Count !== 4'd0) begin errors++; $display("FAIL b2b_done_edge: got busy %0b cfg_err %0b cnt %0d want 0 0 0", cif.busy, cif.cfg_err, cif.Count); end
        tick();
        cif.start = 1'b0;
        checks++; if (cif.busy !== 1'b1 || cif.pass_left !== 4'd1 || cif.Count !== 4'd0) begin errors++; $display("FAIL b2b_accept: got busy %0b pl %0d cnt %0d want 1 1 0", cif.busy, cif.pass_left, cif.Count); end
        tick(); tick(); tick(); tick(); tick();
        checks++; if (cif.done !== 1'b1 || cif.Count !== 4'd3) begin errors++; $display("FAIL b2b_done: got done %0b cnt %0d want 1 3", cif.done, cif.Count); end
        tick();
    endtask

    task automatic test_err();
        start_sweep(4'd2, 4'd5, 4'd1);
        tick(); tick(); tick();
        checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL err_clean: got %0b want 0", cif.err); end
        force_val = 4'd7;
        force_en  = 1'b1;
        tick();
        force_en = 1'b0;
        checks++; if (cif.err !== CHECK_EN) begin errors++; $display("FAIL err_set: got %0b want %0b", cif.err, CHECK_EN); end
        tick(); tick(); tick(); tick();
        checks++; if (cif.done !== 1'b1 || cif.err !== CHECK_EN) begin errors++; $display("FAIL err_done: got done %0b err %0b want 1 %0b", cif.done, cif.err, CHECK_EN); end
        tick();
        checks++; if (cif.err !== CHECK_EN) begin errors++; $display("FAIL err_sticky: got %0b want %0b", cif.err, CHECK_EN); end
        start_sweep(4'd1, 4'd3, 4'd1);
        checks++; if (cif.err !== 1'b0 || cif.busy !== 1'b1) begin errors++; $display("FAIL err_clear: got err %0b busy %0b want 0 1", cif.err, cif.busy); end
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_narrow();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the 4-bit up/down counter in this codebase.
- Drives the counter's direction (`UD`) and active-low clear (`CntClr_n`) and watches its `Count`.
- Makes the counter ramp from 0, then bounce between a programmed floor `lo` and ceiling `hi` for a programmed number of passes.
- Ends with a `done` pulse and returns the counter to 0.
- Sits between the test/control logic that issues `start` and the free-running counter, which has no enable and counts on every clock while its clear is high.

## Interface
Parameters:
- `W`, 4, counter width; only 4 is supported.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `Clear`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: request a sweep; sampled only in IDLE.
- `abort`, in, 1: stop the sweep in UP/DOWN; return to IDLE without `done`.
- `lo`, in, 4: floor value.
- `hi`, in, 4: ceiling value.
- `passes`, in, 4: number of lo→hi→lo passes.
- `Count`, in, 4: current counter value.
- `UD`, out, 1: counter direction; 0 = up, 1 = down. Registered.
- `CntClr_n`, out, 1: counter clear, active-low. Registered.
- `busy`, out, 1: high in UP and DOWN.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `pass_left`, out, 4: number of passes not yet completed.
- `cfg_err`, out, 1: one-cycle pulse when `start` is rejected.
- `err`, out, 1: sticky mismatch flag. Present only with `SWEEP_CHECK_EN`.

## Operation
Assumed counter model:
- At each edge: if `CntClr_n`=0, then `Count`←0.
- Otherwise `Count`←`Count`+1 when `UD`=0, or `Count`−1 when `UD`=1.

Reset (`Clear`=1):
- State←IDLE.
- `UD`=0, `CntClr_n`=0, `busy`=0, `done`=0, `cfg_err`=0, `pass_left`=0, `err`=0.
- Reset overrides every other input and applies in every state, including mid-sweep.

States: IDLE, UP, DOWN, DONE.
- **IDLE**: `CntClr_n`=0, which holds the counter at 0.
  - On `start` with `lo<hi` and `passes`≠0: latch `lo`, `hi`, `passes`; `pass_left`←`passes`; `CntClr_n`←1; `UD`←0; state←UP.
  - On `start` with an invalid configuration: `cfg_err`←1 for one cycle; stay in IDLE.
- **UP**: when `Count`==latched `hi`−1, set `UD`←1 and state←DOWN. The counter reaches `hi` on the same edge and turns down on the next.
- **DOWN**: when `Count`==latched `lo`+1:
  - If `pass_left`>1: `pass_left`−1, `UD`←0, state←UP.
  - If `pass_left`==1: `pass_left`←0, `CntClr_n`←0, `UD`←0, `done`←1, state←DONE.
- **DONE**: lasts one cycle, with `Count`==`lo` during it. Then `done`←0 and state←IDLE; the counter is cleared to 0 on that edge.
- **abort** in UP or DOWN: state←IDLE, `CntClr_n`←0, `UD`←0, `pass_left`←0, no `done`.
- `abort` in IDLE or DONE is ignored.
- If `start` and `abort` are both high in IDLE, `start` wins.
- `start` outside IDLE is ignored and produces no `cfg_err`.
- Inputs `lo`, `hi`, `passes` are used only at start; changes during a sweep have no effect.
- `lo`+1==`hi` is legal: the counter alternates between `hi` and `lo` every cycle.
- `hi`=15 is legal. The counter never wraps because the turn-around happens at `hi`−1.

## Timing
- Take E0 as the edge that accepts `start`. `Count` is still 0 after E0.
- After edge E0+k, `Count`=k for k≤`hi`.
- `done` is high in the cycle after edge E0+`hi`+(2·`passes`−1)·(`hi`−`lo`).
- Latency of `cfg_err`, `abort` response and reset is one edge.

## Configuration
- `SWEEP_CHECK_EN` defined:
  - A shadow register models the counter: `exp`←0 when `CntClr_n`=0, otherwise `exp`±1 per `UD`.
  - While `busy`=1, `Count`≠`exp` sets `err` to 1.
  - `err` is sticky until reset or the next accepted `start`.
- `SWEEP_CHECK_EN` undefined: no shadow logic; `err` is tied to 0.

## Test plan
- Reset mid-sweep (`Count`=3, UP): all outputs reach their reset values after one edge; `Count`=0 one edge later.
- `lo`=2, `hi`=5, `passes`=2: `Count` goes 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2; `done` is high only in the cycle after E14; `pass_left` goes 2→1→0.
- `lo`=3, `hi`=4, `passes`=1: `Count` goes 0→4→3; `done` follows E5; with the same bounds and `passes`=3, `Count` alternates 4,3 until `done` at E9.
- `start` with `lo`=5, `hi`=5 (or `passes`=0): `cfg_err` pulses once; `busy` stays 0.
- `abort` at `Count`=4 in DOWN: `busy` goes 0 next cycle, no `done`, `Count`=0 one edge later; `start` during a sweep is ignored.
- With `SWEEP_CHECK_EN`, force `Count` to 7 in a cycle where 3 is expected: `err`=1 and stays high through DONE; the next accepted `start` clears it.
